// File: rtl/fxp_pkg.sv
// Shared types and constants for the shared fixed-point multiplier scheduler.
package fxp_pkg;

  localparam int unsigned FXP_GRANT_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } fxp_arb_state_t;

  // Width of a requester index; at least one bit even for a single requester.
  function automatic int unsigned fxp_idw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fxp_mul.sv
// Combinational signed fixed-point multiplier with resize, optional rounding and overflow flag.
module fxp_mul #(
  parameter int unsigned A_width_int       = 8,
  parameter int unsigned A_width_frac      = 8,
  parameter int unsigned B_width_int       = 8,
  parameter int unsigned B_width_frac      = 8,
  parameter int unsigned output_width_int  = 8,
  parameter int unsigned output_width_frac = 9,
  parameter int unsigned ROUND             = 1
) (
  input  logic [A_width_int+A_width_frac-1:0]           in1,
  input  logic [B_width_int+B_width_frac-1:0]           in2,
  output logic [output_width_int+output_width_frac-1:0] out,
  output logic                                          overflow
);

  localparam int unsigned WA  = A_width_int + A_width_frac;
  localparam int unsigned WB  = B_width_int + B_width_frac;
  localparam int unsigned WO  = output_width_int + output_width_frac;
  localparam int unsigned WP  = WA + WB;
  localparam int unsigned PF  = A_width_frac + B_width_frac;
  localparam int unsigned OF  = output_width_frac;
  localparam int unsigned SHL = (OF > PF) ? (OF - PF) : 0;
  localparam int unsigned SHR = (PF > OF) ? (PF - OF) : 0;
  // Headroom so rounding never wraps and the overflow test always has sign bits to inspect.
  localparam int unsigned WS  = WP + SHL + WO + 1;

  logic signed [WP-1:0] prod;
  logic signed [WS-1:0] ext;
  logic signed [WS-1:0] scaled;
  logic [WS-WO:0]       hi;

  assign prod = WP'(signed'(in1)) * WP'(signed'(in2));
  assign ext  = WS'(prod);

  // Align the product's binary point to the output format.
  if (SHR > 0) begin : g_shr
    localparam logic signed [WS-1:0] HALF = (ROUND != 0) ? (WS'(1) << (SHR - 1)) : '0;
    assign scaled = (ext + HALF) >>> SHR;
  end else begin : g_shl
    assign scaled = ext <<< SHL;
  end

  // Fits iff every bit from the output sign bit upward is a copy of the sign.
  assign hi       = scaled[WS-1:WO-1];
  assign out      = scaled[WO-1:0];
  assign overflow = ~((&hi) | (~|hi));

endmodule

// File: rtl/fxp_rr_arbiter.sv
// Combinational rotate-priority arbiter: first set request at or above ptr, wrapping.
module fxp_rr_arbiter
  import fxp_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = fxp_idw(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            any
);

  int unsigned idx;

  // Scan requesters starting at ptr; the first hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!any) begin
        idx = (32'(ptr) + k) % NREQ;
        if (req[IDW'(idx)]) begin
          any     = 1'b1;
          gnt_idx = IDW'(idx);
        end
      end
    end
    if (any) begin
      gnt = NREQ'(1) << gnt_idx;
    end
  end

endmodule

// File: rtl/fxp_mul_arb.sv
// Round-robin scheduler sharing one fxp_mul among NREQ requesters.
// Optional per-requester saturating grant counters: define FXP_MUL_ARB_GRANT_CNT_EN.
module fxp_mul_arb
  import fxp_pkg::*;
#(
  parameter int unsigned NREQ              = 4,
  parameter int unsigned A_width_int       = 8,
  parameter int unsigned A_width_frac      = 8,
  parameter int unsigned B_width_int       = 8,
  parameter int unsigned B_width_frac      = 8,
  parameter int unsigned output_width_int  = 8,
  parameter int unsigned output_width_frac = 9,
  parameter int unsigned ROUND             = 1
) (
  input  logic                                               clk,
  input  logic                                               rstn,
  input  logic [NREQ-1:0]                                    req_valid,
  output logic [NREQ-1:0]                                    req_ready,
  input  logic [NREQ*(A_width_int+A_width_frac)-1:0]         req_a,
  input  logic [NREQ*(B_width_int+B_width_frac)-1:0]         req_b,
  output logic                                               rsp_valid,
  input  logic                                               rsp_ready,
  output logic [output_width_int+output_width_frac-1:0]      rsp_data,
  output logic                                               rsp_overflow,
  output logic [fxp_idw(NREQ)-1:0]                           rsp_id
`ifdef FXP_MUL_ARB_GRANT_CNT_EN
  ,
  output logic [NREQ*FXP_GRANT_CNT_W-1:0]                    grant_cnt
`endif
);

  localparam int unsigned WA  = A_width_int + A_width_frac;
  localparam int unsigned WB  = B_width_int + B_width_frac;
  localparam int unsigned WO  = output_width_int + output_width_frac;
  localparam int unsigned IDW = fxp_idw(NREQ);

  fxp_arb_state_t  state_q, state_d;
  logic [IDW-1:0]  ptr_q, id_q, gnt_idx;
  logic [NREQ-1:0] gnt;
  logic            any, grant;
  logic [WA-1:0]   a_q, sel_a;
  logic [WB-1:0]   b_q, sel_b;
  logic [WO-1:0]   mul_out;
  logic            mul_ovf;

  fxp_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  fxp_mul #(
    .A_width_int       (A_width_int),
    .A_width_frac      (A_width_frac),
    .B_width_int       (B_width_int),
    .B_width_frac      (B_width_frac),
    .output_width_int  (output_width_int),
    .output_width_frac (output_width_frac),
    .ROUND             (ROUND)
  ) u_mul (
    .in1      (a_q),
    .in2      (b_q),
    .out      (mul_out),
    .overflow (mul_ovf)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and grant; grants only happen in IDLE and never while reset is asserted.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    grant     = 1'b0;
    case (state_q)
      IDLE: begin
        if (any && rstn) begin
          req_ready = gnt;
          grant     = 1'b1;
          state_d   = CALC;
        end
      end
      CALC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_a = req_a[i*WA +: WA];
        sel_b = req_b[i*WB +: WB];
      end
    end
  end

  // Latch the granted operands and advance the rotation pointer past the winner.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= '0;
      id_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else if (grant) begin
      ptr_q <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
      id_q  <= gnt_idx;
      a_q   <= sel_a;
      b_q   <= sel_b;
    end
  end

  // Response registers: capture in CALC, hold through RESP until accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_overflow <= 1'b0;
      rsp_id       <= '0;
    end else if (state_q == CALC) begin
      rsp_valid    <= 1'b1;
      rsp_data     <= mul_out;
      rsp_overflow <= mul_ovf;
      rsp_id       <= id_q;
    end else if ((state_q == RESP) && rsp_ready) begin
      rsp_valid    <= 1'b0;
    end
  end

`ifdef FXP_MUL_ARB_GRANT_CNT_EN
  for (genvar i = 0; i < NREQ; i++) begin : g_cnt
    logic [FXP_GRANT_CNT_W-1:0] cnt_q;

    // Saturating count of grants to requester i.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                           cnt_q <= '0;
      else if (grant && gnt[i] && ~&cnt_q) cnt_q <= cnt_q + FXP_GRANT_CNT_W'(1);
    end

    assign grant_cnt[i*FXP_GRANT_CNT_W +: FXP_GRANT_CNT_W] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_fxp_mul_arb.sv
// Directed self-checking bench for fxp_mul_arb at default parameters.
module tb_fxp_mul_arb;

  localparam int NREQ = 4;
  localparam int WA   = 16;
  localparam int WB   = 16;
  localparam int WO   = 17;
  localparam int IDW  = 2;

  typedef struct {
    int              id;
    logic [WA-1:0]   a;
    logic [WB-1:0]   b;
    logic [WO-1:0]   d;
    logic            ovf;
    logic            chk_d;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*WA-1:0]   req_a;
  logic [NREQ*WB-1:0]   req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [WO-1:0]        rsp_data;
  logic                 rsp_overflow;
  logic [IDW-1:0]       rsp_id;
`ifdef FXP_MUL_ARB_GRANT_CNT_EN
  logic [NREQ*16-1:0]   grant_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs [9];

  fxp_mul_arb #(
    .NREQ              (NREQ),
    .A_width_int       (8),
    .A_width_frac      (8),
    .B_width_int       (8),
    .B_width_frac      (8),
    .output_width_int  (8),
    .output_width_frac (9),
    .ROUND             (1)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_overflow (rsp_overflow),
    .rsp_id       (rsp_id)
`ifdef FXP_MUL_ARB_GRANT_CNT_EN
    ,
    .grant_cnt    (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  // Wait (bounded) for req_ready to become nonzero at the current sample point.
  task automatic wait_grant(input string name, input logic [NREQ-1:0] exp);
    int w;
    w = 0;
    #1;
    while (req_ready == '0 && w < 10) begin
      tick();
      w++;
    end
    check(name, 32'(req_ready), 32'(exp));
  endtask

  // One full request/response transaction from a single requester.
  task automatic run_vec(input vec_t v, input int n);
    logic [NREQ-1:0] one;
    one = 4'(1) << v.id;
    req_a = '0;
    req_b = '0;
    req_a[v.id*WA +: WA] = v.a;
    req_b[v.id*WB +: WB] = v.b;
    req_valid = one;
    wait_grant($sformatf("v%0d_grant", n), one);
    tick();
    req_valid = '0;
    #1;
    check($sformatf("v%0d_calc_valid", n), 32'(rsp_valid), 32'(0));
    tick();
    check($sformatf("v%0d_valid", n), 32'(rsp_valid), 32'(1));
    check($sformatf("v%0d_id", n), 32'(rsp_id), 32'(v.id));
    check($sformatf("v%0d_ovf", n), 32'(rsp_overflow), 32'(v.ovf));
    if (v.chk_d) check($sformatf("v%0d_data", n), 32'(rsp_data), 32'(v.d));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check($sformatf("v%0d_done", n), 32'(rsp_valid), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ng, last, cyc, eid;

    // id, a, b, expected data (Q8.9), overflow, check data
    vecs[0] = '{0, 16'h0180, 16'h0200, 17'h00600, 1'b0, 1'b1}; // 1.5 * 2.0 = 3.0
    vecs[1] = '{2, 16'hFF00, 16'h0080, 17'h1FF00, 1'b0, 1'b1}; // -1.0 * 0.5 = -0.5
    vecs[2] = '{1, 16'h6400, 16'h6400, 17'h00000, 1'b1, 1'b0}; // 100 * 100 overflows
    vecs[3] = '{3, 16'h0001, 16'h0040, 17'h00001, 1'b0, 1'b1}; // half LSB rounds up
    vecs[4] = '{0, 16'hFFFF, 16'h0060, 17'h1FFFF, 1'b0, 1'b1}; // -0.75 LSB rounds to -1
    vecs[5] = '{1, 16'h0300, 16'hFE80, 17'h1F700, 1'b0, 1'b1}; // 3 * -1.5 = -4.5
    vecs[6] = '{2, 16'h8000, 16'h0100, 17'h10000, 1'b0, 1'b1}; // -128 is the most negative output
    vecs[7] = '{3, 16'h7FFF, 16'h0100, 17'h0FFFE, 1'b0, 1'b1}; // near max positive
    vecs[8] = '{0, 16'h8000, 16'hFF00, 17'h00000, 1'b1, 1'b0}; // +128 overflows

    rstn      = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    #2;
    check("rst_req_ready", 32'(req_ready), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_rsp_data", 32'(rsp_data), 32'(0));
    check("rst_rsp_ovf", 32'(rsp_overflow), 32'(0));
    check("rst_rsp_id", 32'(rsp_id), 32'(0));
    tick();
    tick();
    req_valid = '0;
    rstn = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Backpressure: response held for 5 cycles while another request waits.
    req_a = '0;
    req_b = '0;
    req_a[1*WA +: WA] = 16'h0200;
    req_b[1*WB +: WB] = 16'h0300;
    req_a[3*WA +: WA] = 16'h0100;
    req_b[3*WB +: WB] = 16'hFE00;
    req_valid = 4'b0010;
    wait_grant("bp_grant", 4'b0010);
    tick();
    req_valid = '0;
    tick();
    req_valid = 4'b1000;
    #1;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d_valid", c), 32'(rsp_valid), 32'(1));
      check($sformatf("bp%0d_data", c), 32'(rsp_data), 32'h00C00);
      check($sformatf("bp%0d_id", c), 32'(rsp_id), 32'(1));
      check($sformatf("bp%0d_ovf", c), 32'(rsp_overflow), 32'(0));
      check($sformatf("bp%0d_ready", c), 32'(req_ready), 32'(0));
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_accept_no_grant", 32'(req_ready), 32'(0));
    tick();
    rsp_ready = 1'b0;
    #1;
    check("bp_idle_valid", 32'(rsp_valid), 32'(0));
    check("bp_idle_grant", 32'(req_ready), 32'b1000);
    tick();
    req_valid = '0;
    tick();
    check("bp2_valid", 32'(rsp_valid), 32'(1));
    check("bp2_id", 32'(rsp_id), 32'(3));
    check("bp2_data", 32'(rsp_data), 32'h1FC00);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Round robin from a fresh pointer with all requesters busy.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*WA +: WA] = 16'((i + 1) << 8);
      req_b[i*WB +: WB] = 16'h0100;
    end
    req_valid = '1;
    rsp_ready = 1'b1;
    #1;
    ng = 0;
    last = 0;
    cyc = 0;
    while (ng < 5 && cyc < 40) begin
      if (req_ready != '0) begin
        check($sformatf("rr%0d_order", ng), 32'(req_ready), 32'(4'(1) << (ng % 4)));
        if (ng > 0) check($sformatf("rr%0d_spacing", ng), 32'(cyc - last), 32'(3));
        last = cyc;
        ng++;
      end
      if (rsp_valid) begin
        eid = (ng - 1) % 4;
        check($sformatf("rr%0d_id", ng), 32'(rsp_id), 32'(eid));
        check($sformatf("rr%0d_data", ng), 32'(rsp_data), 32'((eid + 1) << 9));
      end
      tick();
      cyc++;
    end
    check("rr_count", 32'(ng), 32'(5));
    req_valid = '0;
    tick();
    tick();
    tick();
    rsp_ready = 1'b0;

    // Reset while a result is in CALC: it must never appear.
    req_valid = 4'b0100;
    wait_grant("mid_grant", 4'b0100);
    tick();
    req_valid = '1;
    #1;
    rstn = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 32'(0));
    check("mid_rst_data", 32'(rsp_data), 32'(0));
    check("mid_rst_id", 32'(rsp_id), 32'(0));
    check("mid_rst_ready", 32'(req_ready), 32'(0));
    tick();
    req_valid = '0;
    tick();
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("mid_noresp%0d", c), 32'(rsp_valid), 32'(0));
      tick();
    end
    req_valid = '1;
    #1;
    check("mid_first_grant", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    tick();
    check("mid_resp_valid", 32'(rsp_valid), 32'(1));
    check("mid_resp_id", 32'(rsp_id), 32'(0));
    check("mid_resp_data", 32'(rsp_data), 32'h00200);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fxp_mul_arb.md
# fxp_mul_arb

Round-robin scheduler that shares one combinational fixed-point multiplier (`fxp_mul`) among `NREQ` requesters. It owns the single multiplier instance, grants one requester at a time, and registers the operands and the sized product. It returns the result with the requester ID over a valid/ready response channel. It sits between several datapath clients (filter taps, scaling stages) and the shared multiplier resource.

## Interface
- `NREQ`, 4: number of requesters, 2..16.
- `A_width_int` / `A_width_frac`, 8 / 8: operand A format, signed two's complement.
- `B_width_int` / `B_width_frac`, 8 / 8: operand B format.
- `output_width_int` / `output_width_frac`, 8 / 9: result format, passed to `fxp_mul`.
- `ROUND`, 1: passed to `fxp_mul`. 1 = round to nearest, 0 = truncate.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rstn`  in  1  reset; **asynchronous, active-low**.
- `req_valid`  in  NREQ  per-requester operand valid.
- `req_ready`  out  NREQ  per-requester accept, one-hot or zero.
- `req_a`  in  NREQ*WA  packed operand A, requester i at `[i*WA +: WA]`, WA = A_width_int+A_width_frac.
- `req_b`  in  NREQ*WB  packed operand B, same packing.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_data`  out  output_width_int+output_width_frac  product.
- `rsp_overflow`  out  1  overflow flag from `fxp_mul`.
- `rsp_id`  out  IDW = max(1, $clog2(NREQ))  index of the requester that produced the result.

## Operation
- FSM states: IDLE, CALC, RESP.
- **IDLE**
  - If any `req_valid` is set, grant the first set bit searching upward from `ptr` with wrap-around.
  - `req_ready[g]` = 1 combinationally in the same cycle.
  - Latch `req_a[g]`, `req_b[g]` and `g`; set `ptr` = (g+1) mod NREQ; go to CALC.
  - If no `req_valid` is set, stay in IDLE with `ptr` unchanged.
- **CALC**
  - The `fxp_mul` instance sees the latched operands.
  - Register its `out`, `overflow` and the latched ID into the `rsp_*` registers; go to RESP.
- **RESP**
  - `rsp_valid` = 1.
  - On `rsp_ready` = 1, go to IDLE; no grant is made in that cycle.
  - Otherwise hold all `rsp_*` outputs stable.
- `req_ready` is 0 in CALC and RESP.
- Requester rules:
  - A requester must hold `req_valid` and its operands stable until `req_ready` is seen.
  - Dropping `req_valid` before the grant is legal and simply removes the request.
- Arithmetic follows `fxp_mul` exactly:
  - The full product is signed, (A_int+B_int).(A_frac+B_frac).
  - It is resized to the output format with ROUND.
  - `overflow` is 1 when the integer part does not fit.
- `NREQ` = 1 degenerates to a registered multiplier with `rsp_id` = 0.

## Timing
- Reset (async assert, sync release): state = IDLE, `ptr` = 0, and `rsp_valid`, `rsp_data`, `rsp_overflow`, `rsp_id` = 0. `req_ready` = 0 while `rstn` is low.
- Latency: a grant in cycle t gives `rsp_valid` = 1 in cycle t+2.
- Throughput: with `rsp_ready` tied high, one result every 3 cycles.
- The `req_ready` to `req_valid` path is combinational. The `rsp_*` outputs are registered, with no combinational path from any input.
- A simultaneous `rsp_ready` and new `req_valid` in RESP is not granted until the following IDLE cycle.
- Reset in CALC or RESP drops the in-flight result without emitting it.

## Configuration
- `FXP_MUL_ARB_GRANT_CNT_EN` defined:
  - Adds output `grant_cnt`, NREQ*16 bits: a per-requester 16-bit saturating count of grants.
  - Counters reset to 0 and stick at 0xFFFF.
- Not defined: the port and counters are absent; all other behaviour is identical.

## Structure
- Shared package `fxp_pkg`:
  - typedef `fxp_arb_state_t` (IDLE, CALC, RESP);
  - constant `FXP_GRANT_CNT_W` = 16.
- Sub-module `fxp_rr_arbiter`, a combinational rotate-priority grant.
  - Inputs: `req` [NREQ], `ptr` [IDW].
  - Outputs: `gnt` one-hot [NREQ], `gnt_idx` [IDW], `any`.
- One `fxp_mul` instance inside `fxp_mul_arb`.

## Test plan
- **Basic multiply**, default params: requester 0 sends a=0x0180 (1.5), b=0x0200 (2.0). Expect `rsp_data` = 0x00600 (3.0 in Q8.9), overflow 0, `rsp_id` 0, `rsp_valid` 2 cycles after `req_ready`.
- **Signed multiply**: requester 2 sends a=0xFF00 (-1.0), b=0x0080 (0.5). Expect `rsp_data` = 0x1FF00 (-0.5), `rsp_id` 2.
- **Overflow**: a=0x6400 (100), b=0x6400. Expect `rsp_overflow` = 1.
- **Round robin**: all four `req_valid` held high and `rsp_ready` = 1. Expect grant order 0,1,2,3,0, one grant every 3 cycles.
- **Backpressure**: `rsp_ready` = 0 for 5 cycles in RESP. Expect `rsp_*` stable and `req_ready` all 0 throughout; the accept on cycle 6 returns to IDLE.
- **Reset mid-operation**: deassert `rstn` in CALC. Expect all outputs 0 immediately, `ptr` = 0, and no response emitted; the first grant after release goes to requester 0.
